// File: rtl/inst_mem_prog.sv
// Runtime-loadable instruction memory: registered one-cycle fetch port plus a
// byte-serial programming port that assembles little-endian words into the array.
module inst_mem_prog #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000013)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_fetch_data,
    output logic              o_fetch_valid,
    input  logic              i_prog_en,
    input  logic              i_prog_byte_valid,
    input  logic [7:0]        i_prog_byte,
    output logic              o_prog_busy,
    output logic              o_prog_done,
    output logic [ADDR_W:0]   o_prog_count,
    output logic              o_prog_overflow
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_prog_count;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_fetch_valid;

    logic              w_accept;
    logic              w_word_done;
    logic              w_we;
    logic              w_start;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_asm;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_in_range;

    // Array is zero at elaboration and deliberately untouched by reset.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1] = '{default: '0};

    assign w_wr_idx   = r_wptr[IDX_W-1:0];
    assign w_rd_idx   = i_fetch_addr[IDX_W-1:0];
    assign w_in_range = ({1'b0, i_fetch_addr} < LP_DEPTH);
    assign w_start    = (r_state == S_IDLE) && i_prog_en;

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_word_done = 1'b0;
        w_we        = 1'b0;
        w_wdata     = r_word;
        w_asm       = r_word;
        for (int b = 0; b < BYTES; b++) begin
            if (CNT_W'(b) == r_byte_cnt) begin
                w_asm[b*8 +: 8] = i_prog_byte;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (i_prog_en) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A byte presented in the same cycle prog_en drops is discarded.
                if (!i_prog_en) begin
                    w_next = (r_byte_cnt == '0) ? S_IDLE : S_FLUSH;
                end else if (i_prog_byte_valid) begin
                    w_accept = 1'b1;
                    if (r_byte_cnt == LAST_LANE) begin
                        w_word_done = 1'b1;
                        w_we        = 1'b1;
                        w_wdata     = w_asm;
                    end
                end
            end
            S_FLUSH: begin
                w_next = S_IDLE;
                w_we   = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= w_wdata;
        end
    end

    // Assembly buffer is cleared at every word boundary so a flushed partial word has zero upper lanes.
    always_ff @(posedge i_clk) begin
        if (w_start || w_word_done) begin
            r_word <= '0;
        end else if (w_accept) begin
            r_word <= w_asm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_wptr       <= '0;
            r_prog_count <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (r_state != S_IDLE) && (w_next == S_IDLE);
            if (w_start) begin
                r_byte_cnt   <= '0;
                r_wptr       <= '0;
                r_prog_count <= '0;
                r_overflow   <= 1'b0;
            end else if (w_word_done) begin
                r_byte_cnt <= '0;
                if (r_wptr == LAST_ADDR) begin
                    r_wptr     <= '0;
                    r_overflow <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (r_prog_count != LP_DEPTH) begin
                    r_prog_count <= r_prog_count + 1'b1;
                end
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end else if (r_state == S_FLUSH) begin
                r_byte_cnt <= '0;
                if (r_prog_count != LP_DEPTH) begin
                    r_prog_count <= r_prog_count + 1'b1;
                end
            end
        end
    end

    // Fetch is served only in IDLE; an idle cycle without request keeps the last data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
        end else if (r_state == S_IDLE) begin
            r_fetch_valid <= i_fetch_req;
            if (i_fetch_req) begin
                r_fetch_data <= w_in_range ? r_mem[w_rd_idx] : NOP_WORD;
            end
        end else begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= NOP_WORD;
        end
    end

    assign o_fetch_data    = r_fetch_data;
    assign o_fetch_valid   = r_fetch_valid;
    assign o_prog_busy     = r_busy;
    assign o_prog_done     = r_done;
    assign o_prog_count    = r_prog_count;
    assign o_prog_overflow = r_overflow;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Bench for inst_mem_prog: two instances (ADDR_W=9/DEPTH=256 and DEPTH=4) share one
// stimulus stream; a behavioural model feeds a per-cycle expected-result queue.
module tb_inst_mem_prog;

    localparam logic [31:0] NOP = 32'h00000013;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       fetch_req  = 1'b0;
    logic [8:0] fetch_addr = '0;
    logic       prog_en    = 1'b0;
    logic       pbv        = 1'b0;
    logic [7:0] pbyte      = '0;
    logic [7:0] b_addr;

    logic [31:0] a_data, b_data;
    logic        a_vld, b_vld, a_busy, b_busy, a_done, b_done, a_ovf, b_ovf;
    logic [9:0]  a_cnt;
    logic [8:0]  b_cnt;

    assign b_addr = fetch_addr[7:0];

    inst_mem_prog #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .NOP_WORD(NOP)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_data(a_data), .o_fetch_valid(a_vld), .i_prog_en(prog_en),
        .i_prog_byte_valid(pbv), .i_prog_byte(pbyte), .o_prog_busy(a_busy),
        .o_prog_done(a_done), .o_prog_count(a_cnt), .o_prog_overflow(a_ovf)
    );

    inst_mem_prog #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .NOP_WORD(NOP)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_req(fetch_req), .i_fetch_addr(b_addr),
        .o_fetch_data(b_data), .o_fetch_valid(b_vld), .i_prog_en(prog_en),
        .i_prog_byte_valid(pbv), .i_prog_byte(pbyte), .o_prog_busy(b_busy),
        .o_prog_done(b_done), .o_prog_count(b_cnt), .o_prog_overflow(b_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] da;
        logic [31:0] db;
        logic        busy;
        logic        done;
        logic [9:0]  ca;
        logic [8:0]  cb;
        logic        oa;
        logic        ob;
    } exp_t;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          dep [2] = '{256, 4};
    logic [31:0] mdl [2][256];
    int          wp  [2];
    int          cnt [2];
    logic        ovf [2];
    logic [31:0] last [2];
    int          ph;
    int          bcnt;
    logic [31:0] word;
    logic [7:0]  bq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @step %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic mwrite(input logic [31:0] w, input bit full);
        for (int i = 0; i < 2; i++) begin
            mdl[i][wp[i]] = w;
            if (cnt[i] < dep[i]) cnt[i]++;
            if (full) begin
                if (wp[i] == dep[i] - 1) begin
                    wp[i]  = 0;
                    ovf[i] = 1'b1;
                end else begin
                    wp[i]++;
                end
            end
        end
    endtask

    // One clock: model the edge from the current inputs, queue the expectation, then check.
    task automatic step();
        exp_t        e;
        int          a;
        logic [31:0] d;
        e.vld = (ph == 0) && fetch_req;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? int'(fetch_addr) : int'(fetch_addr[7:0]);
            if (ph != 0) d = NOP;
            else if (fetch_req) d = (a < dep[i]) ? mdl[i][a] : NOP;
            else d = last[i];
            last[i] = d;
            if (i == 0) e.da = d; else e.db = d;
        end
        e.done = 1'b0;
        case (ph)
            0: if (prog_en) begin
                ph = 1; bcnt = 0; word = '0;
                for (int i = 0; i < 2; i++) begin wp[i] = 0; cnt[i] = 0; ovf[i] = 1'b0; end
            end
            1: if (!prog_en) begin
                if (bcnt == 0) begin ph = 0; e.done = 1'b1; end
                else ph = 2;
            end else if (pbv) begin
                word[bcnt*8 +: 8] = pbyte;
                bcnt++;
                if (bcnt == 4) begin mwrite(word, 1'b1); bcnt = 0; word = '0; end
            end
            default: begin
                mwrite(word, 1'b0); word = '0; bcnt = 0; ph = 0; e.done = 1'b1;
            end
        endcase
        e.busy = (ph != 0);
        e.ca   = 10'(cnt[0]);
        e.cb   = 9'(cnt[1]);
        e.oa   = ovf[0];
        e.ob   = ovf[1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("fetch_valid_a", a_vld, e.vld);
        chk("fetch_valid_b", b_vld, e.vld);
        chk("fetch_data_a", a_data, e.da);
        chk("fetch_data_b", b_data, e.db);
        chk("prog_busy_a", a_busy, e.busy);
        chk("prog_busy_b", b_busy, e.busy);
        chk("prog_done_a", a_done, e.done);
        chk("prog_done_b", b_done, e.done);
        chk("prog_count_a", a_cnt, e.ca);
        chk("prog_count_b", b_cnt, e.cb);
        chk("prog_overflow_a", a_ovf, e.oa);
        chk("prog_overflow_b", b_ovf, e.ob);
    endtask

    task automatic fetch(input logic [8:0] ad);
        fetch_req  = 1'b1;
        fetch_addr = ad;
        step();
    endtask

    task automatic idle(input int n);
        fetch_req = 1'b0; prog_en = 1'b0; pbv = 1'b0;
        repeat (n) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) bq.push_back(w[b*8 +: 8]);
    endtask

    // Opens a session, streams bq (with one idle gap, fetches requested throughout)
    // and, when asked, closes it with a stray byte in the cycle prog_en falls.
    task automatic load(input bit finish);
        fetch_req = 1'b0; prog_en = 1'b1; pbv = 1'b0;
        step();
        for (int k = 0; k < bq.size(); k++) begin
            pbv = 1'b1; pbyte = bq[k]; fetch_req = 1'b1; fetch_addr = 9'(k);
            step();
            if (k == 2) begin
                pbv = 1'b0;
                step();
            end
        end
        pbv = 1'b0;
        if (finish) begin
            prog_en = 1'b0; pbv = 1'b1; pbyte = 8'hEE;
            step();
            pbv = 1'b0;
            for (int k = 0; k < 2 && ph != 0; k++) step();
            fetch_req = 1'b0;
        end
        bq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_req = 1'b0; prog_en = 1'b0; pbv = 1'b0;
        #2;
        chk("rst_fetch_data_a", a_data, 32'h0);
        chk("rst_fetch_data_b", b_data, 32'h0);
        chk("rst_fetch_valid_a", a_vld, 1'b0);
        chk("rst_fetch_valid_b", b_vld, 1'b0);
        chk("rst_busy_a", a_busy, 1'b0);
        chk("rst_busy_b", b_busy, 1'b0);
        chk("rst_done_a", a_done, 1'b0);
        chk("rst_done_b", b_done, 1'b0);
        chk("rst_count_a", a_cnt, 10'd0);
        chk("rst_count_b", b_cnt, 9'd0);
        chk("rst_overflow_a", a_ovf, 1'b0);
        chk("rst_overflow_b", b_ovf, 1'b0);
        ph = 0; bcnt = 0; word = '0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; ovf[i] = 1'b0; wp[i] = 0; last[i] = '0;
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) mdl[i][j] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Empty array: in-range fetch gives 0, then hold with fetch_req low.
        fetch(9'd5);
        idle(1);

        // Two full words, then fetch right in the first IDLE cycle.
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
        load(1'b1);
        fetch(9'd1);
        fetch(9'd0);
        idle(2);

        // One full word plus a two-byte partial word that FLUSH writes.
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load(1'b1);
        fetch(9'd1);
        fetch(9'd0);
        idle(1);

        // Back-to-back fetches, including one beyond DEPTH.
        fetch(9'd0);
        fetch(9'd1);
        fetch(9'd2);
        fetch(9'd300);
        idle(1);

        // Five words: the DEPTH=4 instance wraps and saturates its count.
        for (int k = 0; k < 5; k++) push_word(32'hA1B2C3D4 + 32'h01010101 * k);
        load(1'b1);
        for (int k = 0; k < 5; k++) fetch(9'(k));
        idle(1);

        // Session abandoned by reset mid-word: written words stay, no done pulse.
        push_word(32'hCAFE0005);
        push_word(32'hBEEF0006);
        bq.push_back(8'h77);
        bq.push_back(8'h88);
        load(1'b0);
        do_reset();
        idle(3);
        fetch(9'd0);
        fetch(9'd1);
        fetch(9'd2);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
